// File: rtl/race_pkg.sv
`default_nettype none
// ============================================================================
// Module   : race_pkg
// Brief    : Shared state encodings and car-physics constants for race_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package race_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_RACE      = 2'd2,
        ST_RESULT    = 2'd3
    } race_state_t;

    localparam int          C_GEAR_W         = 3;
    localparam int          C_SPEED_W        = 6;
    localparam int          C_SPEED_PER_GEAR = 4;
    localparam logic [1:0]  C_CD_START       = 2'd3;

endpackage
`default_nettype wire

// File: rtl/race_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : race_ctrl_if
// Brief    : Menu/keyboard inputs and race status outputs of race_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface race_ctrl_if #(
    parameter int N_PLAYERS = 2,
    parameter int POS_W     = 11
);
    logic                   start_game;
    logic [N_PLAYERS-1:0]   key_accel;
    logic [N_PLAYERS-1:0]   key_shift;
    logic [1:0]             state;
    logic [1:0]             countdown;
    logic [N_PLAYERS*POS_W-1:0] xpos;
    logic [N_PLAYERS*3-1:0] gear;
    logic [N_PLAYERS-1:0]   false_start;
    logic [1:0]             winner;
    logic                   winner_valid;
    logic                   back_to_menu;

    modport master (
        output start_game, key_accel, key_shift,
        input  state, countdown, xpos, gear, false_start, winner, winner_valid, back_to_menu
    );

    modport slave (
        input  start_game, key_accel, key_shift,
        output state, countdown, xpos, gear, false_start, winner, winner_valid, back_to_menu
    );
endinterface
`default_nettype wire

// File: rtl/car_physics.sv
`default_nettype none
// ============================================================================
// Module   : car_physics
// Brief    : Speed, gear, position and false-start tracking for one car.
// Revision : 1.0 - initial release
// ============================================================================
module car_physics
    import race_pkg::*;
#(
    parameter int POS_W     = 11,
    parameter int TRACK_LEN = 768,
    parameter int MAX_GEAR  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  race_state_t         i_state,
    input  logic                i_clear,
    input  logic                i_tick,
    input  logic                i_accel,
    input  logic                i_shift,
    output logic [POS_W-1:0]    o_xpos,
    output logic [C_GEAR_W-1:0] o_gear,
    output logic                o_false_start,
    output logic                o_dq_next,
    output logic                o_finish
);
    localparam logic [POS_W:0]          C_TRACK    = (POS_W+1)'(TRACK_LEN);
    localparam logic [C_GEAR_W-1:0]     C_MAX_GEAR = C_GEAR_W'(MAX_GEAR);

    logic [POS_W-1:0]       r_xpos,  w_xpos_race,  w_xpos_next;
    logic [C_GEAR_W-1:0]    r_gear,  w_gear_race,  w_gear_next;
    logic [C_SPEED_W-1:0]   r_speed, w_speed_race, w_speed_next;
    logic [C_SPEED_W-1:0]   w_limit;
    logic [POS_W:0]         w_sum;
    logic                   r_fs, w_fs_next;

    // Racing update kept free of i_clear so o_finish never loops back through the FSM.
    always_comb begin
        w_gear_race  = r_gear;
        w_speed_race = r_speed;
        w_xpos_race  = r_xpos;
        w_sum        = '0;
        if (i_shift && (r_gear < C_MAX_GEAR))
            w_gear_race = r_gear + C_GEAR_W'(1);
        w_limit = C_SPEED_W'(w_gear_race) * C_SPEED_W'(C_SPEED_PER_GEAR);
        if (i_tick) begin
            if (i_accel)
                w_speed_race = (r_speed >= w_limit) ? w_limit : r_speed + C_SPEED_W'(1);
            else
                w_speed_race = (r_speed == '0) ? '0 : r_speed - C_SPEED_W'(1);
            if (w_speed_race > w_limit)
                w_speed_race = w_limit;
            w_sum       = {1'b0, r_xpos} + (POS_W+1)'(w_speed_race);
            w_xpos_race = (w_sum >= C_TRACK) ? C_TRACK[POS_W-1:0] : w_sum[POS_W-1:0];
        end
    end

    always_comb begin
        w_xpos_next  = r_xpos;
        w_gear_next  = r_gear;
        w_speed_next = r_speed;
        w_fs_next    = r_fs;
        if (i_clear) begin
            w_xpos_next  = '0;
            w_gear_next  = C_GEAR_W'(1);
            w_speed_next = '0;
            w_fs_next    = 1'b0;
        end else if (i_state == ST_COUNTDOWN) begin
            if (i_shift)
                w_fs_next = 1'b1;
        end else if ((i_state == ST_RACE) && !r_fs) begin
            w_xpos_next  = w_xpos_race;
            w_gear_next  = w_gear_race;
            w_speed_next = w_speed_race;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xpos  <= '0;
            r_gear  <= C_GEAR_W'(1);
            r_speed <= '0;
            r_fs    <= 1'b0;
        end else begin
            r_xpos  <= w_xpos_next;
            r_gear  <= w_gear_next;
            r_speed <= w_speed_next;
            r_fs    <= w_fs_next;
        end
    end

    assign o_xpos        = r_xpos;
    assign o_gear        = r_gear;
    assign o_false_start = r_fs;
    assign o_dq_next     = r_fs | ((i_state == ST_COUNTDOWN) & i_shift);
    assign o_finish      = (i_state == ST_RACE) && !r_fs && i_tick &&
                           (w_xpos_race == C_TRACK[POS_W-1:0]);

endmodule
`default_nettype wire

// File: rtl/race_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : race_ctrl
// Brief    : Race game sequencer: tick divider, countdown/race/result FSM.
// Revision : 1.0 - initial release
// ============================================================================
module race_ctrl
    import race_pkg::*;
#(
    parameter int N_PLAYERS    = 2,
    parameter int POS_W        = 11,
    parameter int TRACK_LEN    = 768,
    parameter int TICK_DIV     = 1083333,
    parameter int COUNT_TICKS  = 60,
    parameter int MAX_GEAR     = 5,
    parameter int RESULT_TICKS = 180
) (
    input  logic        clk,
    input  logic        rst_n,
    race_ctrl_if.slave  bus
);
    localparam int C_DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int C_CNT_MAX = (COUNT_TICKS > RESULT_TICKS) ? COUNT_TICKS : RESULT_TICKS;
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
    localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(TICK_DIV - 1);
    localparam logic [C_CNT_W-1:0] C_CD_LAST  = C_CNT_W'(COUNT_TICKS - 1);
    localparam logic [C_CNT_W-1:0] C_RES_LAST = C_CNT_W'(RESULT_TICKS - 1);

    logic                   r_rst_meta, r_rst_sync_n;
    race_state_t            r_state, w_state_next;
    logic [1:0]             r_countdown, w_countdown_next;
    logic [C_DIV_W-1:0]     r_div, w_div_next;
    logic [C_CNT_W-1:0]     r_cnt, w_cnt_next;
    logic [1:0]             r_winner, w_winner_next, w_first;
    logic                   r_winner_valid, w_valid_next;
    logic                   r_btm, w_btm_next;
    logic                   w_tick, w_clear;
    logic [N_PLAYERS-1:0]   w_dq_next, w_finish, w_fs;
    logic [N_PLAYERS*POS_W-1:0]    w_xpos;
    logic [N_PLAYERS*C_GEAR_W-1:0] w_gear;

    // Assert asynchronously, release two clocks later in step with clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_meta   <= 1'b0;
            r_rst_sync_n <= 1'b0;
        end else begin
            r_rst_meta   <= 1'b1;
            r_rst_sync_n <= r_rst_meta;
        end
    end

    assign w_tick  = (r_div == C_DIV_LAST);
    assign w_clear = (w_state_next == ST_IDLE);

    always_comb begin
        w_state_next     = r_state;
        w_countdown_next = r_countdown;
        w_winner_next    = r_winner;
        w_valid_next     = r_winner_valid;
        w_btm_next       = 1'b0;
        w_div_next       = w_tick ? '0 : r_div + C_DIV_W'(1);
        w_cnt_next       = w_tick ? r_cnt + C_CNT_W'(1) : r_cnt;
        w_first          = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--)
            if (w_finish[i]) w_first = 2'(i);
        case (r_state)
            ST_IDLE: begin
                if (bus.start_game) begin
                    w_state_next     = ST_COUNTDOWN;
                    w_div_next       = '0;
                    w_cnt_next       = '0;
                    w_countdown_next = C_CD_START;
                    w_winner_next    = '0;
                    w_valid_next     = 1'b0;
                end
            end
            ST_COUNTDOWN: begin
                if (w_tick && (r_cnt == C_CD_LAST)) begin
                    w_cnt_next = '0;
                    if (r_countdown == 2'd1) begin
                        w_countdown_next = 2'd0;
                        w_state_next     = (&w_dq_next) ? ST_RESULT : ST_RACE;
                    end else begin
                        w_countdown_next = r_countdown - 2'd1;
                    end
                end
            end
            ST_RACE: begin
                if (|w_finish) begin
                    w_state_next  = ST_RESULT;
                    w_winner_next = w_first;
                    w_valid_next  = 1'b1;
                    w_cnt_next    = '0;
                end
            end
            ST_RESULT: begin
                if (w_tick && (r_cnt == C_RES_LAST)) begin
                    w_state_next     = ST_IDLE;
                    w_btm_next       = 1'b1;
                    w_countdown_next = C_CD_START;
                    w_cnt_next       = '0;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge r_rst_sync_n) begin
        if (!r_rst_sync_n) begin
            r_state        <= ST_IDLE;
            r_countdown    <= C_CD_START;
            r_div          <= '0;
            r_cnt          <= '0;
            r_winner       <= '0;
            r_winner_valid <= 1'b0;
            r_btm          <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_countdown    <= w_countdown_next;
            r_div          <= w_div_next;
            r_cnt          <= w_cnt_next;
            r_winner       <= w_winner_next;
            r_winner_valid <= w_valid_next;
            r_btm          <= w_btm_next;
        end
    end

    generate
        for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_car
            car_physics #(
                .POS_W     (POS_W),
                .TRACK_LEN (TRACK_LEN),
                .MAX_GEAR  (MAX_GEAR)
            ) u_car (
                .clk           (clk),
                .rst_n         (r_rst_sync_n),
                .i_state       (r_state),
                .i_clear       (w_clear),
                .i_tick        (w_tick),
                .i_accel       (bus.key_accel[gi]),
                .i_shift       (bus.key_shift[gi]),
                .o_xpos        (w_xpos[gi*POS_W +: POS_W]),
                .o_gear        (w_gear[gi*C_GEAR_W +: C_GEAR_W]),
                .o_false_start (w_fs[gi]),
                .o_dq_next     (w_dq_next[gi]),
                .o_finish      (w_finish[gi])
            );
        end
    endgenerate

    assign bus.state        = r_state;
    assign bus.countdown    = r_countdown;
    assign bus.xpos         = w_xpos;
    assign bus.gear         = w_gear;
    assign bus.false_start  = w_fs;
    assign bus.winner       = r_winner;
    assign bus.winner_valid = r_winner_valid;
    assign bus.back_to_menu = r_btm;

endmodule
`default_nettype wire

// File: tb/tb_race_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_race_ctrl
// Brief    : Self-checking bench for race_ctrl against a per-game reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_race_ctrl;
    localparam int N            = 2;
    localparam int POS_W        = 11;
    localparam int TRACK_LEN    = 40;
    localparam int TICK_DIV     = 4;
    localparam int COUNT_TICKS  = 2;
    localparam int MAX_GEAR     = 5;
    localparam int RESULT_TICKS = 3;
    localparam int VEC_W        = 2 + 2 + N*POS_W + N*3 + N + 2 + 1 + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    race_ctrl_if #(.N_PLAYERS(N), .POS_W(POS_W)) bus ();

    race_ctrl #(
        .N_PLAYERS(N), .POS_W(POS_W), .TRACK_LEN(TRACK_LEN), .TICK_DIV(TICK_DIV),
        .COUNT_TICKS(COUNT_TICKS), .MAX_GEAR(MAX_GEAR), .RESULT_TICKS(RESULT_TICKS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [VEC_W-1:0] obs;
    assign obs = {bus.state, bus.countdown, bus.xpos, bus.gear, bus.false_start,
                  bus.winner, bus.winner_valid, bus.back_to_menu};

    // Reference game: phase 0 menu, 1 lights, 2 racing, 3 podium.
    int m_phase, m_cd, m_div, m_ticks, m_win;
    bit m_wv, m_btm;
    int m_x [N];
    int m_g [N];
    int m_s [N];
    bit m_fs[N];

    function automatic logic [VEC_W-1:0] model_vec();
        logic [N*POS_W-1:0] xv;
        logic [N*3-1:0]     gv;
        logic [N-1:0]       fv;
        for (int i = 0; i < N; i++) begin
            xv[i*POS_W +: POS_W] = POS_W'(m_x[i]);
            gv[i*3 +: 3]         = 3'(m_g[i]);
            fv[i]                = m_fs[i];
        end
        return {2'(m_phase), 2'(m_cd), xv, gv, fv, 2'(m_win), m_wv, m_btm};
    endfunction

    task automatic model_clear_cars();
        for (int i = 0; i < N; i++) begin
            m_x[i] = 0; m_g[i] = 1; m_s[i] = 0; m_fs[i] = 0;
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_cd = 3; m_div = 0; m_ticks = 0; m_win = 0; m_wv = 0; m_btm = 0;
        model_clear_cars();
    endtask

    task automatic model_step(input logic start, input logic [N-1:0] accel, input logic [N-1:0] shift);
        bit tick;
        bit all_dq;
        int first;
        tick  = (m_div == TICK_DIV - 1);
        m_div = tick ? 0 : m_div + 1;
        m_btm = 0;
        case (m_phase)
            0: if (start) begin
                m_phase = 1; m_div = 0; m_ticks = 0; m_cd = 3; m_win = 0; m_wv = 0;
            end
            1: begin
                for (int i = 0; i < N; i++) if (shift[i]) m_fs[i] = 1;
                if (tick) begin
                    m_ticks = m_ticks + 1;
                    if (m_ticks == COUNT_TICKS) begin
                        m_ticks = 0;
                        m_cd    = m_cd - 1;
                        if (m_cd == 0) begin
                            all_dq = 1;
                            for (int i = 0; i < N; i++) all_dq = all_dq & m_fs[i];
                            m_phase = all_dq ? 3 : 2;
                        end
                    end
                end
            end
            2: begin
                first = -1;
                for (int i = 0; i < N; i++) begin
                    if (!m_fs[i]) begin
                        if (shift[i] && m_g[i] < MAX_GEAR) m_g[i] = m_g[i] + 1;
                        if (tick) begin
                            m_s[i] = accel[i] ? m_s[i] + 1 : m_s[i] - 1;
                            if (m_s[i] > 4 * m_g[i]) m_s[i] = 4 * m_g[i];
                            if (m_s[i] < 0) m_s[i] = 0;
                            m_x[i] = m_x[i] + m_s[i];
                            if (m_x[i] > TRACK_LEN) m_x[i] = TRACK_LEN;
                            if (m_x[i] == TRACK_LEN && first < 0) first = i;
                        end
                    end
                end
                if (first >= 0) begin
                    m_phase = 3; m_win = first; m_wv = 1; m_ticks = 0;
                end
            end
            default: if (tick) begin
                m_ticks = m_ticks + 1;
                if (m_ticks == RESULT_TICKS) begin
                    m_phase = 0; m_btm = 1; m_cd = 3; m_ticks = 0;
                    model_clear_cars();
                end
            end
        endcase
    endtask

    task automatic step(input logic start, input logic [N-1:0] accel, input logic [N-1:0] shift);
        @(negedge clk);
        bus.start_game = start;
        bus.key_accel  = accel;
        bus.key_shift  = shift;
        model_step(start, accel, shift);
        @(posedge clk);
        #1;
        bus.start_game = 1'b0;
        bus.key_shift  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        bus.start_game = 1'b0;
        bus.key_accel  = '0;
        bus.key_shift  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs !== model_vec()) begin
            errors++; $display("FAIL reset_state act=%h exp=%h", obs, model_vec());
        end
        checks++;
        if (bus.state !== 2'd0 || bus.countdown !== 2'd3 || bus.gear !== 6'b001_001) begin
            errors++; $display("FAIL reset_const act=%0d/%0d/%b exp=0/3/001001", bus.state, bus.countdown, bus.gear);
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b0, N'($urandom), N'($urandom));
            checks++;
            if (obs !== model_vec()) begin
                errors++; $display("FAIL idle_hold step=%0d act=%h exp=%h", k, obs, model_vec());
            end
        end
    endtask

    task automatic test_countdown();
        int exp_cd, exp_st;
        step(1'b1, '0, '0);
        for (int k = 1; k <= 24; k++) begin
            step(1'b0, '0, '0);
            exp_cd = (k < 8) ? 3 : (k < 16) ? 2 : (k < 24) ? 1 : 0;
            exp_st = (k < 24) ? 1 : 2;
            checks++;
            if (bus.countdown !== 2'(exp_cd) || bus.state !== 2'(exp_st)) begin
                errors++; $display("FAIL countdown k=%0d act=%0d/%0d exp=%0d/%0d", k, bus.countdown, bus.state, exp_cd, exp_st);
            end
            checks++;
            if (obs !== model_vec()) begin
                errors++; $display("FAIL countdown_model k=%0d act=%h exp=%h", k, obs, model_vec());
            end
        end
        do_reset();
    endtask

    task automatic test_solo_accel();
        logic [POS_W-1:0] seen[$];
        logic [POS_W-1:0] last;
        int  want[5] = '{1, 3, 6, 10, 14};
        int  k = 0;
        bit  got = 0;
        logic [1:0] r_win = 0; logic r_wv = 0; logic [POS_W-1:0] r_x0 = 0;
        last = '0;
        step(1'b1, 2'b01, '0);
        while (m_phase != 0 && k < 400) begin
            step(1'b0, 2'b01, '0);
            k++;
            checks++;
            if (obs !== model_vec()) begin
                errors++; $display("FAIL solo_model k=%0d act=%h exp=%h", k, obs, model_vec());
            end
            if (bus.xpos[POS_W-1:0] !== last) begin
                last = bus.xpos[POS_W-1:0];
                seen.push_back(last);
            end
            if (!got && bus.state == 2'd3) begin
                got = 1; r_win = bus.winner; r_wv = bus.winner_valid; r_x0 = bus.xpos[POS_W-1:0];
            end
        end
        checks++;
        if (m_phase != 0) begin errors++; $display("FAIL solo_timeout act=%0d exp=0", m_phase); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (seen.size() <= i || seen[i] !== POS_W'(want[i])) begin
                errors++; $display("FAIL solo_xpos idx=%0d act=%0d exp=%0d", i, (seen.size() > i) ? int'(seen[i]) : -1, want[i]);
            end
        end
        checks++;
        if (!got || r_win !== 2'd0 || r_wv !== 1'b1 || r_x0 !== POS_W'(TRACK_LEN)) begin
            errors++; $display("FAIL solo_winner act=%0d/%0d/%0d exp=0/1/%0d", r_win, r_wv, r_x0, TRACK_LEN);
        end
    endtask

    task automatic test_false_start();
        int k = 0;
        bit got = 0;
        logic [N-1:0] r_fs = 0; logic [POS_W-1:0] r_x1 = 0; logic [1:0] r_win = 0; logic r_wv = 0;
        step(1'b1, 2'b01, '0);
        while (m_phase != 0 && k < 400) begin
            step(1'b0, 2'b01, (k == 5) ? 2'b10 : 2'b00);
            k++;
            checks++;
            if (obs !== model_vec()) begin
                errors++; $display("FAIL fstart_model k=%0d act=%h exp=%h", k, obs, model_vec());
            end
            if (!got && bus.state == 2'd3) begin
                got = 1; r_fs = bus.false_start; r_x1 = bus.xpos[POS_W +: POS_W];
                r_win = bus.winner; r_wv = bus.winner_valid;
            end
        end
        checks++;
        if (!got || r_fs !== 2'b10 || r_x1 !== '0 || r_win !== 2'd0 || r_wv !== 1'b1) begin
            errors++; $display("FAIL fstart_result act=%b/%0d/%0d/%0d exp=10/0/0/1", r_fs, r_x1, r_win, r_wv);
        end
    endtask

    task automatic test_tie();
        int k = 0;
        bit got = 0;
        logic [N*POS_W-1:0] r_x = 0; logic [1:0] r_win = 0; logic r_wv = 0;
        step(1'b1, 2'b11, '0);
        while (m_phase != 0 && k < 400) begin
            step(1'b0, 2'b11, '0);
            k++;
            checks++;
            if (obs !== model_vec()) begin
                errors++; $display("FAIL tie_model k=%0d act=%h exp=%h", k, obs, model_vec());
            end
            if (!got && bus.state == 2'd3) begin
                got = 1; r_x = bus.xpos; r_win = bus.winner; r_wv = bus.winner_valid;
            end
        end
        checks++;
        if (!got || r_x !== {POS_W'(TRACK_LEN), POS_W'(TRACK_LEN)} || r_win !== 2'd0 || r_wv !== 1'b1) begin
            errors++; $display("FAIL tie_result act=%h/%0d/%0d exp=both %0d/0/1", r_x, r_win, r_wv, TRACK_LEN);
        end
    endtask

    task automatic test_all_dq();
        int k = 0;
        int first_after = -1;
        int res_len = 0;
        bit btm_seen = 0;
        logic [1:0] prev;
        logic r_wv = 1;
        step(1'b1, 2'b11, '0);
        prev = bus.state;
        while (m_phase != 0 && k < 400) begin
            step(1'b0, 2'b11, (k == 3) ? 2'b11 : 2'b00);
            k++;
            checks++;
            if (obs !== model_vec()) begin
                errors++; $display("FAIL alldq_model k=%0d act=%h exp=%h", k, obs, model_vec());
            end
            if (prev == 2'd1 && bus.state != 2'd1) begin
                first_after = int'(bus.state); r_wv = bus.winner_valid;
            end
            if (bus.state == 2'd3) res_len++;
            if (bus.back_to_menu === 1'b1) btm_seen = 1;
            prev = bus.state;
        end
        checks++;
        if (first_after != 3 || r_wv !== 1'b0) begin
            errors++; $display("FAIL alldq_skip act=%0d/%0d exp=3/0", first_after, r_wv);
        end
        checks++;
        if (res_len != RESULT_TICKS * TICK_DIV || !btm_seen) begin
            errors++; $display("FAIL alldq_hold act=%0d/%0d exp=%0d/1", res_len, btm_seen, RESULT_TICKS * TICK_DIV);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] acc, sh;
        for (int g = 0; g < 6; g++) begin
            int k = 0;
            step(1'b1, '0, '0);
            while (m_phase != 0 && k < 800) begin
                for (int i = 0; i < N; i++) begin
                    acc[i] = ($urandom_range(0, 99) < 75);
                    sh[i]  = (m_phase == 2) ? ($urandom_range(0, 99) < 5)
                           : (g == 2 && m_phase == 1) ? ($urandom_range(0, 99) < 4) : 1'b0;
                end
                step(1'b0, acc, sh);
                k++;
                checks++;
                if (obs !== model_vec()) begin
                    errors++; $display("FAIL random g=%0d k=%0d act=%h exp=%h", g, k, obs, model_vec());
                end
            end
            checks++;
            if (m_phase != 0) begin errors++; $display("FAIL random_timeout g=%0d act=%0d exp=0", g, m_phase); end
        end
    endtask

    task automatic test_reset_mid_race();
        int k = 0;
        step(1'b1, 2'b11, '0);
        while (!(m_phase == 2 && k > 40) && k < 200) begin
            step(1'b0, 2'b11, N'($urandom_range(0, 3)) & {N{m_phase == 2}});
            k++;
        end
        checks++;
        if (bus.state !== 2'd2) begin errors++; $display("FAIL midrace_setup act=%0d exp=2", bus.state); end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== model_vec() || bus.state !== 2'd0 || bus.countdown !== 2'd3) begin
            errors++; $display("FAIL midrace_reset act=%h exp=%h", obs, model_vec());
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        step(1'b1, '0, '0);
        checks++;
        if (bus.state !== 2'd1 || bus.countdown !== 2'd3) begin
            errors++; $display("FAIL midrace_restart act=%0d/%0d exp=1/3", bus.state, bus.countdown);
        end
        for (int j = 0; j < 12; j++) begin
            step(1'b0, '0, '0);
            checks++;
            if (obs !== model_vec()) begin
                errors++; $display("FAIL midrace_model j=%0d act=%h exp=%h", j, obs, model_vec());
            end
        end
    endtask

    initial begin
        bus.start_game = 1'b0;
        bus.key_accel  = '0;
        bus.key_shift  = '0;
        model_reset();
        test_reset();
        test_countdown();
        test_solo_accel();
        test_false_start();
        test_tie();
        test_all_dq();
        test_random();
        test_reset_mid_race();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/race_ctrl.md
RACE_CTRL -- requirements
Module: race_ctrl

Interface
REQ-001 Parameter N_PLAYERS, default 2, number of racing cars (legal 1..4).
REQ-002 Parameter POS_W, default 11, width of each car x-position.
REQ-003 Parameter TRACK_LEN, default 768, finish-line distance in pixels.
REQ-004 Parameter TICK_DIV, default 1083333, clk cycles per game tick (60 Hz at 65 MHz).
REQ-005 Parameter COUNT_TICKS, default 60, game ticks per countdown step.
REQ-006 Parameter MAX_GEAR, default 5, highest gear (gear width 3 bits).
REQ-007 Parameter RESULT_TICKS, default 180, ticks the result is held before returning to the menu.
REQ-008 clk  in  1  single system clock (65 MHz pixel clock); one clock; reset is asynchronous and active-low.
REQ-009 rst  in  1  asynchronous active-low reset.
REQ-010 start_game  in  1  one-cycle pulse from the game menu.
REQ-011 key_accel  in  N_PLAYERS  per-player accelerator level, 1 = held.
REQ-012 key_shift  in  N_PLAYERS  per-player gear-up one-cycle pulse (rising-edge keyboard output).
REQ-013 state  out  2  0 IDLE, 1 COUNTDOWN, 2 RACE, 3 RESULT.
REQ-014 countdown  out  2  lights value 3,2,1, then 0 = GO.
REQ-015 xpos  out  N_PLAYERS*POS_W  car offsets from start line, player i at bits [i*POS_W +: POS_W].
REQ-016 gear  out  N_PLAYERS*3  current gear per player.
REQ-017 false_start  out  N_PLAYERS  sticky disqualification flag per player.
REQ-018 winner  out  2  index of the winning player; winner_valid  out  1  qualifies it.
REQ-019 back_to_menu  out  1  one-cycle pulse on RESULT exit.

Function
REQ-020 A free-running divider SHALL assert an internal tick for one cycle every TICK_DIV cycles; the divider SHALL restart from 0 on every IDLE->COUNTDOWN transition.
REQ-021 IDLE: all xpos 0, gear 1, speed 0, countdown 3, false_start 0; start_game moves to COUNTDOWN next cycle; start_game is ignored in every other state.
REQ-022 COUNTDOWN: countdown decrements every COUNT_TICKS ticks (3->2->1); on the tick it would leave 1, it becomes 0 and state becomes RACE in the same cycle.
REQ-023 key_shift pulse by player i in COUNTDOWN SHALL set false_start[i]; key_accel is ignored in COUNTDOWN.
REQ-024 RACE, per tick, per non-disqualified player: accel held -> speed+1 saturating at gear*4; released -> speed-1 saturating at 0; speed above the new limit is clamped immediately.
REQ-025 RACE, per tick: xpos += speed, saturating at TRACK_LEN; disqualified players keep xpos 0.
REQ-026 key_shift in RACE SHALL increment gear on the same cycle, saturating at MAX_GEAR; a shift coinciding with a tick uses the new gear limit for that tick.
REQ-027 On the first tick where any xpos reaches TRACK_LEN: state -> RESULT, winner = lowest such index, winner_valid = 1; simultaneous arrivals resolve to the lowest index.
REQ-028 If every player is disqualified at COUNTDOWN->RACE: RACE is skipped, state -> RESULT, winner_valid = 0.
REQ-029 RESULT: all positions, gears and flags frozen; after RESULT_TICKS ticks back_to_menu pulses for one cycle and state returns to IDLE.
REQ-030 Speed register width: 6 bits (max MAX_GEAR*4 = 20); xpos addition done at POS_W+1 bits before saturation.

Reset
REQ-031 rst low SHALL force state IDLE, countdown 3, xpos 0, gear 1, speed 0, false_start 0, winner 0, winner_valid 0, back_to_menu 0, divider 0, asynchronously, in any state including mid-race.
REQ-032 Release of rst SHALL be synchronised by the existing reset block; first state change is no earlier than the first start_game after release.

Structure
REQ-033 State encodings, gear width, and speed-per-gear constant (4) SHALL live in a shared package race_pkg.
REQ-034 Per-player speed/gear/xpos logic SHALL be one sub-module car_physics, instantiated N_PLAYERS times by generate; FSM and divider remain in race_ctrl.

Verification
REQ-035 TICK_DIV=4, COUNT_TICKS=2: start_game -> countdown 3,2,1,0 at ticks 2,4,6; state RACE at tick 6.
REQ-036 P0 holds accel from GO, no shifts, TRACK_LEN=40 -> speed saturates at 4, xpos 1,3,6,10,14..., winner 0 when xpos 40.
REQ-037 P1 shifts during COUNTDOWN -> false_start = 2'b10, xpos1 stays 0, P0 wins with winner_valid 1.
REQ-038 Both players identical stimulus -> simultaneous finish, winner 0.
REQ-039 Both shift in COUNTDOWN -> RESULT directly at GO, winner_valid 0, back_to_menu after RESULT_TICKS ticks.
REQ-040 rst low mid-RACE -> all outputs reset values within the same cycle; state IDLE; next start_game restarts countdown from 3.
